// File: rtl/mem_if_pkg.sv
// Shared types and constants for the data-memory burst initiator.
package mem_if_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned MAX_BURST  = 16;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BEATS_W    = 5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_ISSUE  = 3'd1,
    RD_RESP   = 3'd2,
    WR_WAIT   = 3'd3,
    WR_COMMIT = 3'd4,
    DONE      = 3'd5
  } state_t;

  // Per-burst progress: next byte address and words still to transfer.
  typedef struct packed {
    logic [ADDR_W-1:0]  cur_addr;
    logic [BEATS_W-1:0] beats_left;
  } burst_ctx_t;

  // Zero-length bursts become single words; oversize bursts saturate at MAX_BURST.
  function automatic logic [BEATS_W-1:0] clamp_len(input logic [15:0] len);
    if (len == 16'd0) begin
      return BEATS_W'(1);
    end else if (len > 16'(MAX_BURST)) begin
      return BEATS_W'(MAX_BURST);
    end else begin
      return BEATS_W'(len);
    end
  endfunction

endpackage

// File: rtl/mem_lat_timer.sv
// Read-latency down-counter: reloads to LAT-1 while idle, expires at zero.
module mem_lat_timer #(
  parameter int unsigned LAT = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire_c
);

  localparam int unsigned CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(LAT - 1);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expire_c = (r_cnt == '0);

endmodule

// File: rtl/mem_burst_master.sv
// Burst load/store initiator for the data memory (valid/ready request, backpressured response).
// Optional `ALIGN_CHECK_EN: misaligned requests are rejected with err+done instead of being word-aligned.
module mem_burst_master
  import mem_if_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned LEN_W      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_t            r_state;
  burst_ctx_t        r_ctx;
  logic              r_req_ready;
  logic              r_wr_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_last;
  logic              r_done;
  logic              r_busy;
  logic              r_err;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_we;
  logic              r_mem_re;

  logic              w_misaligned;
  logic [ADDR_W-1:0] w_start_addr;
  logic              w_last;
  logic              w_lat_expire;
  logic [ADDR_W-1:0] w_next_addr;

`ifdef ALIGN_CHECK_EN
  assign w_misaligned = (req_addr[1:0] != 2'b00);
  assign w_start_addr = req_addr;
`else
  assign w_misaligned = 1'b0;
  assign w_start_addr = req_addr & ~ADDR_W'(WORD_BYTES - 1);
`endif

  assign w_last      = (r_ctx.beats_left == BEATS_W'(1));
  assign w_next_addr = r_ctx.cur_addr + ADDR_W'(WORD_BYTES);

  // Counter reloads whenever we are not issuing, so each read beat starts a fresh latency window.
  mem_lat_timer #(
    .LAT (RD_LATENCY)
  ) u_lat_timer (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (r_state != RD_ISSUE),
    .i_en       (r_state == RD_ISSUE),
    .o_expire_c (w_lat_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ctx       <= '0;
      r_req_ready <= 1'b1;
      r_wr_ready  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_last  <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_ctx.cur_addr   <= w_start_addr;
            r_ctx.beats_left <= clamp_len(16'(req_len));
            r_req_ready      <= 1'b0;
            r_busy           <= 1'b1;
            if (w_misaligned) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else if (req_write) begin
              r_state    <= WR_WAIT;
              r_wr_ready <= 1'b1;
            end else begin
              r_state  <= RD_ISSUE;
              r_mem_re <= 1'b1;
            end
          end
        end

        RD_ISSUE: begin
          if (w_lat_expire) begin
            r_rsp_data  <= mem_read_data;
            r_rsp_valid <= 1'b1;
            r_rsp_last  <= w_last;
            r_mem_re    <= 1'b0;
            r_state     <= RD_RESP;
          end
        end

        // Word is held until the consumer takes it; no new read is issued meanwhile.
        RD_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid      <= 1'b0;
            r_rsp_last       <= 1'b0;
            r_ctx.cur_addr   <= w_next_addr;
            r_ctx.beats_left <= r_ctx.beats_left - BEATS_W'(1);
            if (w_last) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state  <= RD_ISSUE;
              r_mem_re <= 1'b1;
            end
          end
        end

        WR_WAIT: begin
          if (wr_valid) begin
            r_mem_wdata <= wr_data;
            r_wr_ready  <= 1'b0;
            r_mem_we    <= 1'b1;
            r_state     <= WR_COMMIT;
          end
        end

        WR_COMMIT: begin
          r_mem_we         <= 1'b0;
          r_ctx.cur_addr   <= w_next_addr;
          r_ctx.beats_left <= r_ctx.beats_left - BEATS_W'(1);
          if (w_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state    <= WR_WAIT;
            r_wr_ready <= 1'b1;
          end
        end

        DONE: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_req_ready <= 1'b1;
        end

        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready      = r_req_ready;
  assign wr_ready       = r_wr_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_data       = r_rsp_data;
  assign rsp_last       = r_rsp_last;
  assign done           = r_done;
  assign busy           = r_busy;
  assign err            = r_err;
  assign mem_addr       = {2'b00, r_ctx.cur_addr[ADDR_W-1:2]};
  assign mem_write_data = r_mem_wdata;
  assign mem_MemWrite   = r_mem_we;
  assign mem_MemRead    = r_mem_re;

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a 16-word combinational memory model.
module tb_mem_burst_master;

  localparam int unsigned RD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [4:0]  req_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rsp_valid, rsp_ready, rsp_last;
  logic [31:0] rsp_data;
  logic        done, busy, err;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_MemWrite, mem_MemRead;

  logic [31:0] mem [16];
  assign mem_read_data = mem_MemRead ? mem[mem_addr[3:0]] : 32'h0;

  int errors = 0;
  int checks = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] rd_addr_q[$];
  int rd_cycles = 0;
  int both_hi   = 0;
  int done_cnt  = 0;
  int err_cnt   = 0;
  logic prev_re = 1'b0;

  mem_burst_master #(.RD_LATENCY(RD_LAT), .LEN_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .done(done), .busy(busy), .err(err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Bus monitor: logs memory traffic and pulse counts once per cycle.
  always @(negedge clk) begin
    if (mem_MemWrite) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_write_data);
    end
    if (mem_MemRead && !prev_re) rd_addr_q.push_back(mem_addr);
    if (mem_MemRead) rd_cycles++;
    if (mem_MemRead && mem_MemWrite) both_hi++;
    if (done) done_cnt++;
    if (err) err_cnt++;
    prev_re = mem_MemRead;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [4:0] l);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_len = l;
    tick();
    req_valid = 1'b0;
  endtask

  // Accepts every response immediately; reports beat count and position of rsp_last.
  task automatic drain_load(output int beats, output int last_at, output int last_cnt, output bit timeout);
    beats = 0; last_at = -1; last_cnt = 0;
    rsp_ready = 1'b1;
    for (int n = 0; n < 300 && !done; n++) begin
      if (rsp_valid) begin
        if (rsp_last) begin last_at = beats; last_cnt++; end
        beats++;
      end
      tick();
    end
    timeout = !done;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({req_ready, busy, wr_ready, rsp_valid, done, err, mem_MemRead, mem_MemWrite} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 10000000",
               {req_ready, busy, wr_ready, rsp_valid, done, err, mem_MemRead, mem_MemWrite});
    end
    checks++;
    if (mem_addr !== 32'h0 || rsp_data !== 32'h0) begin
      errors++; $display("FAIL reset_data: mem_addr=%h rsp_data=%h want 0", mem_addr, rsp_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_load();
    int rc0, n;
    mem[1] = 32'h8;
    rsp_ready = 1'b0;
    rc0 = rd_cycles;
    issue(1'b0, 32'h4, 5'd1);
    checks++;
    if ({mem_MemRead, busy, req_ready} !== 3'b110 || mem_addr !== 32'h1) begin
      errors++;
      $display("FAIL load1_issue: re/busy/rdy=%b addr=%h want 110 addr=1",
               {mem_MemRead, busy, req_ready}, mem_addr);
    end
    n = 0;
    do begin tick(); n++; end while (!rsp_valid && n < 20);
    checks++;
    if (n !== int'(RD_LAT) || rd_cycles - rc0 !== int'(RD_LAT)) begin
      errors++; $display("FAIL load1_latency: wait=%0d rd_cycles=%0d want %0d", n, rd_cycles - rc0, RD_LAT);
    end
    checks++;
    if (rsp_data !== 32'h8 || rsp_last !== 1'b1 || mem_MemRead !== 1'b0) begin
      errors++; $display("FAIL load1_rsp: data=%h last=%b re=%b want 8 1 0", rsp_data, rsp_last, mem_MemRead);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL load1_done: done=%b rsp_valid=%b want 1 0", done, rsp_valid);
    end
    tick();
    checks++;
    if ({req_ready, busy, done} !== 3'b100) begin
      errors++; $display("FAIL load1_idle: rdy/busy/done=%b want 100", {req_ready, busy, done});
    end
  endtask

  task automatic test_store_burst();
    int w0, d0, idx;
    wr_valid = 1'b1; wr_data = 32'hDEAD;
    tick(); tick();
    wr_valid = 1'b0;
    w0 = wr_addr_q.size(); d0 = done_cnt; idx = 0;
    issue(1'b1, 32'h10, 5'd3);
    for (int n = 0; n < 100 && !done; n++) begin
      if (wr_ready) begin
        wr_valid = 1'b1; wr_data = 32'hA + 32'(idx); idx++;
      end else begin
        wr_valid = 1'b0;
      end
      tick();
    end
    wr_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || wr_addr_q.size() - w0 !== 3 || done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL store_count: done=%b writes=%0d dones=%0d want 1 3 1", done, wr_addr_q.size() - w0, done_cnt - d0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_addr_q[w0+i] !== 32'd4 + 32'(i) || wr_data_q[w0+i] !== 32'hA + 32'(i)) begin
          errors++;
          $display("FAIL store_beat%0d: addr=%h data=%h want %h %h", i, wr_addr_q[w0+i], wr_data_q[w0+i],
                   32'd4 + 32'(i), 32'hA + 32'(i));
        end
      end
    end
    tick();
  endtask

  task automatic test_load_backpressure();
    int r0, rc0, beat, hold;
    for (int i = 0; i < 4; i++) mem[8+i] = 32'h11 * 32'(i + 1);
    rsp_ready = 1'b0;
    r0 = rd_addr_q.size(); rc0 = rd_cycles; beat = 0; hold = 0;
    issue(1'b0, 32'h20, 5'd4);
    for (int n = 0; n < 200 && !done; n++) begin
      if (rsp_valid) begin
        if (beat == 1 && hold < 5) begin
          checks++;
          if (rsp_data !== 32'h22 || mem_MemRead !== 1'b0) begin
            errors++; $display("FAIL bp_hold%0d: data=%h re=%b want 22 0", hold, rsp_data, mem_MemRead);
          end
          hold++;
          rsp_ready = 1'b0;
        end else begin
          checks++;
          if (rsp_data !== 32'h11 * 32'(beat + 1) || rsp_last !== (beat == 3)) begin
            errors++;
            $display("FAIL bp_beat%0d: data=%h last=%b want %h %b", beat, rsp_data, rsp_last,
                     32'h11 * 32'(beat + 1), beat == 3);
          end
          rsp_ready = 1'b1;
          beat++;
        end
      end else begin
        rsp_ready = 1'b0;
      end
      tick();
    end
    rsp_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || beat !== 4 || rd_cycles - rc0 !== 4 * int'(RD_LAT) || rd_addr_q.size() - r0 !== 4) begin
      errors++;
      $display("FAIL bp_totals: done=%b beats=%0d rd_cycles=%0d reads=%0d want 1 4 %0d 4",
               done, beat, rd_cycles - rc0, rd_addr_q.size() - r0, 4 * RD_LAT);
    end else begin
      checks++;
      if (rd_addr_q[r0] !== 32'd8 || rd_addr_q[r0+1] !== 32'd9 || rd_addr_q[r0+2] !== 32'd10 || rd_addr_q[r0+3] !== 32'd11) begin
        errors++;
        $display("FAIL bp_addrs: got %h %h %h %h want 8 9 a b", rd_addr_q[r0], rd_addr_q[r0+1],
                 rd_addr_q[r0+2], rd_addr_q[r0+3]);
      end
    end
    tick();
  endtask

  task automatic test_wrap();
    int r0, w0, e0, got;
    logic [31:0] data_q[$];
    mem[15] = 32'hCAFE000F; mem[0] = 32'hCAFE0000;
    r0 = rd_addr_q.size(); w0 = wr_addr_q.size(); e0 = err_cnt;
    rsp_ready = 1'b1;
    issue(1'b0, 32'hFFFF_FFFC, 5'd2);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h80; req_len = 5'd1;
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL wrap_busy: req_ready=%b busy=%b want 0 1", req_ready, busy);
    end
    for (int n = 0; n < 100 && !done; n++) begin
      if (rsp_valid) data_q.push_back(rsp_data);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    got = rd_addr_q.size() - r0;
    checks++;
    if (got !== 2 || data_q.size() !== 2) begin
      errors++; $display("FAIL wrap_count: reads=%0d rsps=%0d want 2 2", got, data_q.size());
    end else begin
      checks++;
      if (rd_addr_q[r0] !== 32'h3FFF_FFFF || rd_addr_q[r0+1] !== 32'h0 ||
          data_q[0] !== 32'hCAFE000F || data_q[1] !== 32'hCAFE0000) begin
        errors++;
        $display("FAIL wrap_seq: addr %h %h data %h %h want 3fffffff 0 cafe000f cafe0000",
                 rd_addr_q[r0], rd_addr_q[r0+1], data_q[0], data_q[1]);
      end
    end
    tick();
    checks++;
    if (err_cnt !== e0 || wr_addr_q.size() !== w0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_side: errs=%0d writes=%0d busy=%b want 0 0 0", err_cnt - e0, wr_addr_q.size() - w0, busy);
    end
  endtask

  task automatic test_len_clamp();
    int beats, last_at, last_cnt;
    bit to;
    issue(1'b0, 32'h8, 5'd0);
    drain_load(beats, last_at, last_cnt, to);
    checks++;
    if (to || beats !== 1 || last_at !== 0 || last_cnt !== 1) begin
      errors++; $display("FAIL len0: timeout=%b beats=%0d last_at=%0d lasts=%0d want 0 1 0 1", to, beats, last_at, last_cnt);
    end
    tick();
    issue(1'b0, 32'h0, 5'd20);
    drain_load(beats, last_at, last_cnt, to);
    checks++;
    if (to || beats !== 16 || last_at !== 15 || last_cnt !== 1) begin
      errors++; $display("FAIL len20: timeout=%b beats=%0d last_at=%0d lasts=%0d want 0 16 15 1", to, beats, last_at, last_cnt);
    end
    tick();
  endtask

  task automatic test_align();
    int r0, e0;
    r0 = rd_addr_q.size(); e0 = err_cnt;
    mem[1] = 32'h8;
`ifdef ALIGN_CHECK_EN
    issue(1'b0, 32'h6, 5'd1);
    checks++;
    if ({err, done, mem_MemRead, mem_MemWrite} !== 4'b1100) begin
      errors++; $display("FAIL align_err: err/done/re/we=%b want 1100", {err, done, mem_MemRead, mem_MemWrite});
    end
    tick();
    checks++;
    if ({err, done, req_ready, busy} !== 4'b0010 || rd_addr_q.size() !== r0) begin
      errors++;
      $display("FAIL align_after: err/done/rdy/busy=%b reads=%0d want 0010 0", {err, done, req_ready, busy}, rd_addr_q.size() - r0);
    end
`else
    begin
      int beats, last_at, last_cnt;
      bit to;
      issue(1'b0, 32'h6, 5'd1);
      checks++;
      if (mem_MemRead !== 1'b1 || mem_addr !== 32'h1) begin
        errors++; $display("FAIL align_addr: re=%b addr=%h want 1 1", mem_MemRead, mem_addr);
      end
      rsp_ready = 1'b1;
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h8) begin
        errors++; $display("FAIL align_data: valid=%b data=%h want 1 8", rsp_valid, rsp_data);
      end
      drain_load(beats, last_at, last_cnt, to);
      checks++;
      if (to || err_cnt !== e0) begin
        errors++; $display("FAIL align_noerr: timeout=%b err_pulses=%0d want 0 0", to, err_cnt - e0);
      end
      tick();
    end
`endif
  endtask

  task automatic test_reset_mid();
    int w0, d0;
    w0 = wr_addr_q.size(); d0 = done_cnt;
    issue(1'b1, 32'h40, 5'd4);
    for (int n = 0; n < 100; n++) begin
      if (wr_addr_q.size() - w0 == 1 && wr_ready) break;
      if (wr_ready) begin wr_valid = 1'b1; wr_data = 32'h44; end
      else wr_valid = 1'b0;
      tick();
    end
    checks++;
    if (wr_addr_q.size() - w0 !== 1 || wr_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_setup: writes=%0d wr_ready=%b want 1 1", wr_addr_q.size() - w0, wr_ready);
    end
    wr_valid = 1'b1; wr_data = 32'h55; rst = 1'b1;
    tick();
    checks++;
    if ({req_ready, busy, wr_ready, mem_MemWrite, done} !== 5'b10000) begin
      errors++;
      $display("FAIL rstmid_idle: rdy/busy/wrdy/we/done=%b want 10000", {req_ready, busy, wr_ready, mem_MemWrite, done});
    end
    rst = 1'b0; wr_valid = 1'b0;
    repeat (5) tick();
    checks++;
    if (done_cnt !== d0 || wr_addr_q.size() - w0 !== 1) begin
      errors++; $display("FAIL rstmid_after: dones=%0d writes=%0d want 0 1", done_cnt - d0, wr_addr_q.size() - w0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0; rsp_ready = 1'b0;
    test_reset();
    test_single_load();
    test_store_burst();
    test_load_backpressure();
    test_wrap();
    test_len_clamp();
    test_align();
    test_reset_mid();
    checks++;
    if (both_hi !== 0) begin
      errors++; $display("FAIL rd_wr_exclusive: overlap cycles=%0d want 0", both_hi);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
